// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the MEM->WB writeback stage.
package writeback_stage_pkg;

  // Writeback value source selected by ResultSrcM (2'b11 is reserved and behaves as ALU)
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  // Load width/sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM: IDLE accepts work, WAIT holds a load until memory answers or times out
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage inputs and writeback-stage outputs of the MEM->WB boundary.
interface writeback_stage_if;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemReadM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] PCPlus4M;
  logic [31:0] ReadDataM;
  logic        MemReadyM;
  logic        StallM;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        LoadErrW;

  // Upstream pipeline / memory side: drives M signals, observes stall and W results
  modport master (
    output RegWriteM, ResultSrcM, MemReadM, funct3M, RdM, ALUResultM, PCPlus4M,
           ReadDataM, MemReadyM,
    input  StallM, RegWriteW, RdW, ResultW, LoadErrW
  );

  // Writeback stage side
  modport slave (
    input  RegWriteM, ResultSrcM, MemReadM, funct3M, RdM, ALUResultM, PCPlus4M,
           ReadDataM, MemReadyM,
    output StallM, RegWriteW, RdW, ResultW, LoadErrW
  );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Combinational load-data extraction: picks the byte/half/word at the low
// address bits and sign- or zero-extends it, flagging misalignment and
// unsupported funct3 encodings.
module load_extend
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension according to the load type
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'b0, byte_sel};
      F3_LH: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = addr[0];
      end
      F3_LHU: begin
        data     = {16'b0, half_sel};
        misalign = addr[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = |addr;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM->WB pipeline register and register-file write side. Loads that are
// not answered immediately stall the pipeline; a hung load is abandoned
// after MEM_TIMEOUT cycles and reported on LoadErrW.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave wb
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      result_q, result_d;
  logic             load_err_q, load_err_d;

  logic             stall_c;
  logic             capture_c;
  logic             timeout_c;
  logic             load_fault_c;
  logic [31:0]      ld_data;
  logic             ld_misalign;
  logic             ld_illegal;

  load_extend u_load_extend (
    .funct3  (wb.funct3M),
    .addr    (wb.ALUResultM[1:0]),
    .rdata   (wb.ReadDataM),
    .data    (ld_data),
    .misalign(ld_misalign),
    .illegal (ld_illegal)
  );

  // Load-wait sequencing: decides stall, capture or timeout this cycle
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_c    = 1'b0;
    capture_c  = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb.MemReadM && !wb.MemReadyM) begin
          stall_c    = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          capture_c = 1'b1;
        end
      end
      WAIT: begin
        if (wb.MemReadyM) begin
          capture_c  = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LIMIT) begin
          timeout_c  = 1'b1;
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          stall_c    = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Next W register contents: captured result, or a bubble while stalled/aborted
  always_comb begin
    load_fault_c = wb.MemReadM && (ld_misalign || ld_illegal);
    reg_write_d  = 1'b0;
    rd_d         = '0;
    result_d     = '0;
    load_err_d   = timeout_c;
    if (capture_c) begin
      reg_write_d = wb.RegWriteM && (wb.RdM != 5'd0) && !load_fault_c;
      rd_d        = wb.RdM;
      load_err_d  = load_fault_c;
      case (wb.ResultSrcM)
        RES_LOAD: result_d = ld_data;
        RES_PC4:  result_d = wb.PCPlus4M;
        default:  result_d = wb.ALUResultM;
      endcase
    end
  end

  // FSM state, wait counter and registered W outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      load_err_q  <= load_err_d;
    end
  end

  // Stall is combinational so upstream freezes in the same cycle; reset overrides it
  assign wb.StallM    = stall_c && !rst;
  assign wb.RegWriteW = reg_write_q;
  assign wb.RdW       = rd_q;
  assign wb.ResultW   = result_q;
  assign wb.LoadErrW  = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized instructions, each judged by a transaction-level reference.
module tb_writeback_stage;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  writeback_stage_if wb();

  writeback_stage #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .wb (wb.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference load extraction from the architectural rules
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata, output bit bad);
    int unsigned a, b, h;
    a   = addr % 4;
    b   = (rdata >> (8 * a)) & 32'hFF;
    h   = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    bad = 1'b0;
    case (f3)
      3'd0: return (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
      3'd4: return 32'(b);
      3'd1: begin bad = (a % 2) != 0; return (h >= 32768) ? (32'(h) | 32'hFFFF_0000) : 32'(h); end
      3'd5: begin bad = (a % 2) != 0; return 32'(h); end
      3'd2: begin bad = (a != 0); return rdata; end
      default: begin bad = 1'b1; return 32'd0; end
    endcase
  endfunction

  task automatic drive(input logic rw, input logic [1:0] src, input logic mr, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] rdata);
    wb.RegWriteM  = rw;
    wb.ResultSrcM = src;
    wb.MemReadM   = mr;
    wb.funct3M    = f3;
    wb.RdM        = rd;
    wb.ALUResultM = alu;
    wb.PCPlus4M   = pc4;
    wb.ReadDataM  = rdata;
  endtask

  // Present one instruction (held while stalled); a load sees MemReadyM on its
  // w-th cycle. Must be called just after a rising edge.
  task automatic run_instr(input string name, input logic rw, input logic [1:0] src,
                           input logic mr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [31:0] rdata, input int w, output int stalls);
    bit          bad, err, done;
    logic [31:0] ld, exp_res;
    drive(rw, src, mr, f3, rd, alu, pc4, rdata);
    ld      = ref_load(f3, alu, rdata, bad);
    err     = mr && bad;
    exp_res = (src == 2'b01) ? ld : (src == 2'b10) ? pc4 : alu;
    stalls  = 0;
    done    = 1'b0;
    for (int k = 0; k <= MEM_TIMEOUT && !done; k++) begin
      logic ready, tout, st;
      ready = mr ? (k == w) : 1'($urandom);
      wb.MemReadyM = ready;
      tout = mr && !ready && (k == MEM_TIMEOUT - 1);
      st   = mr && !ready && !tout;
      @(negedge clk);
      check({name, "/stall"}, 32'(wb.StallM), 32'(st));
      @(posedge clk);
      #1;
      if (st || tout) begin
        check({name, "/bub_we"}, 32'(wb.RegWriteW), 32'd0);
        check({name, "/bub_rd"}, 32'(wb.RdW), 32'd0);
        check({name, "/bub_res"}, wb.ResultW, 32'd0);
        check({name, "/bub_err"}, 32'(wb.LoadErrW), 32'(tout));
        if (st) stalls++;
        if (tout) done = 1'b1;
      end else begin
        if (err) begin
          check({name, "/err_we"}, 32'(wb.RegWriteW), 32'd0);
          check({name, "/err"}, 32'(wb.LoadErrW), 32'd1);
        end else begin
          check({name, "/we"}, 32'(wb.RegWriteW), 32'(rw && (rd != 5'd0)));
          check({name, "/rd"}, 32'(wb.RdW), 32'(rd));
          check({name, "/res"}, wb.ResultW, exp_res);
          check({name, "/err"}, 32'(wb.LoadErrW), 32'd0);
        end
        done = 1'b1;
      end
    end
    check({name, "/done"}, 32'(done), 32'd1);
    n_txn++;
    $display("txn %0d %s: rd=%0d src=%0d load=%0b f3=%0d stalls=%0d we=%0b result=0x%08h err=%0b",
             n_txn, name, rd, src, mr, f3, stalls, wb.RegWriteW, wb.ResultW, wb.LoadErrW);
  endtask

  initial begin
    int s;
    drive(1'b0, 2'b00, 1'b1, 3'd2, 5'd0, 32'd0, 32'd0, 32'd0);
    wb.MemReadyM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(wb.RegWriteW), 32'd0);
    check("rst_rd", 32'(wb.RdW), 32'd0);
    check("rst_res", wb.ResultW, 32'd0);
    check("rst_err", 32'(wb.LoadErrW), 32'd0);
    check("rst_stall", 32'(wb.StallM), 32'd0);
    rst = 1'b0;

    // Async reset mid-cycle clears live outputs
    run_instr("pre", 1'b1, 2'b00, 1'b0, 3'd0, 5'd7, 32'hDEAD_BEEF, 32'd0, 32'd0, 0, s);
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(wb.RegWriteW), 32'd0);
    check("arst_rd", 32'(wb.RdW), 32'd0);
    check("arst_res", wb.ResultW, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr("t1_alu", 1'b1, 2'b00, 1'b0, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 0, s);
    check("t1_res", wb.ResultW, 32'h0000_1234);
    check("t1_rd", 32'(wb.RdW), 32'd5);

    run_instr("t2_lb", 1'b1, 2'b01, 1'b1, 3'd0, 5'd9, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 0, s);
    check("t2_lb_res", wb.ResultW, 32'hFFFF_FF80);
    check("t2_lb_stalls", 32'(s), 32'd0);
    run_instr("t2_lbu", 1'b1, 2'b01, 1'b1, 3'd4, 5'd9, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 0, s);
    check("t2_lbu_res", wb.ResultW, 32'h0000_0080);

    run_instr("t3_lhu", 1'b1, 2'b01, 1'b1, 3'd5, 5'd10, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 3, s);
    check("t3_stalls", 32'(s), 32'd3);
    check("t3_res", wb.ResultW, 32'h0000_BEEF);
    check("t3_we", 32'(wb.RegWriteW), 32'd1);

    run_instr("t4_tmo", 1'b1, 2'b01, 1'b1, 3'd2, 5'd11, 32'h0000_0100, 32'd0, 32'h1111_2222,
              MEM_TIMEOUT, s);
    check("t4_stalls", 32'(s), 32'(MEM_TIMEOUT - 1));
    check("t4_err", 32'(wb.LoadErrW), 32'd1);
    run_instr("t4_next", 1'b1, 2'b00, 1'b0, 3'd0, 5'd12, 32'h0000_0042, 32'd0, 32'd0, 0, s);

    run_instr("t5_mis", 1'b1, 2'b01, 1'b1, 3'd2, 5'd13, 32'h0000_1002, 32'd0, 32'hCAFE_F00D, 1, s);
    check("t5_err", 32'(wb.LoadErrW), 32'd1);
    check("t5_we", 32'(wb.RegWriteW), 32'd0);
    run_instr("t5_x0", 1'b1, 2'b00, 1'b0, 3'd0, 5'd0, 32'h0000_7777, 32'd0, 32'd0, 0, s);
    check("t5_x0_we", 32'(wb.RegWriteW), 32'd0);

    run_instr("t6_jal", 1'b1, 2'b10, 1'b0, 3'd0, 5'd1, 32'h0000_5555, 32'h0000_0100, 32'd0, 0, s);
    check("t6_res", wb.ResultW, 32'h0000_0100);

    // Reset while a load is waiting: no write and no error pulse afterwards
    drive(1'b1, 2'b01, 1'b1, 3'd2, 5'd3, 32'h0000_0000, 32'd0, 32'h5A5A_5A5A);
    wb.MemReadyM = 1'b0;
    @(negedge clk);
    check("t6w_stall0", 32'(wb.StallM), 32'd1);
    @(posedge clk);
    #1;
    check("t6w_bub", 32'(wb.RegWriteW), 32'd0);
    @(negedge clk);
    check("t6w_stall1", 32'(wb.StallM), 32'd1);
    #1 rst = 1'b1;
    wb.MemReadyM = 1'b1;
    #1;
    check("t6w_rst_stall", 32'(wb.StallM), 32'd0);
    check("t6w_rst_err", 32'(wb.LoadErrW), 32'd0);
    @(posedge clk);
    #1;
    check("t6w_rst_we", 32'(wb.RegWriteW), 32'd0);
    check("t6w_rst_err2", 32'(wb.LoadErrW), 32'd0);
    rst = 1'b0;
    run_instr("t6_after", 1'b1, 2'b00, 1'b0, 3'd0, 5'd14, 32'h0000_0ABC, 32'd0, 32'd0, 0, s);

    // Randomized mix of ALU, PC+4, reserved-select and load instructions
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic [31:0] alu, pc4, rdata;
      logic [4:0]  rd;
      logic        rw;
      kind  = $urandom_range(0, 3);
      alu   = $urandom;
      pc4   = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      rw    = ($urandom_range(0, 7) != 0);
      case (kind)
        0: run_instr("r_alu", rw, 2'b00, 1'b0, 3'($urandom), rd, alu, pc4, rdata, 0, s);
        1: run_instr("r_pc4", rw, 2'b10, 1'b0, 3'($urandom), rd, alu, pc4, rdata, 0, s);
        2: run_instr("r_load", rw, 2'b01, 1'b1, 3'($urandom), rd, alu, pc4, rdata,
                     $urandom_range(0, MEM_TIMEOUT), s);
        default: run_instr("r_res3", rw, 2'b11, 1'b0, 3'($urandom), rd, alu, pc4, rdata, 0, s);
      endcase
    end
    run_instr("final", 1'b1, 2'b00, 1'b0, 3'd0, 5'd2, 32'h0000_0001, 32'd0, 32'd0, 0, s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
